// File: rtl/multi_trigger.sv
// multi_trigger: runs rounds of actor launches until a round executes nothing.
// A round launches every selected actor once, waits for all of them to report
// done, then relaunches if any actor returned EXECUTED_CODE. In actor-trigger
// mode a busy network postpones the finish through a backoff delay.
module multi_trigger #(
  parameter int unsigned NUM_ACTORS    = 4,
  parameter int unsigned MODE          = 0,
  parameter logic [31:0] EXECUTED_CODE = 32'd1,
  parameter int unsigned SLEEP_CYCLES  = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     ap_start,
  output logic                     ap_done,
  output logic                     ap_ready,
  output logic                     ap_idle,
  input  logic                     network_idle,
  input  logic [NUM_ACTORS-1:0]    actor_enable,
  input  logic [32*NUM_ACTORS-1:0] actor_return,
  input  logic [NUM_ACTORS-1:0]    actor_done,
  input  logic [NUM_ACTORS-1:0]    actor_ready,
  input  logic [NUM_ACTORS-1:0]    actor_idle,
  input  logic [NUM_ACTORS-1:0]    actor_launch_predicate,
  output logic [NUM_ACTORS-1:0]    actor_start,
  output logic [31:0]              round_count
);

  typedef enum logic [2:0] {
    ST_STAND_BY,
    ST_LAUNCH,
    ST_WAIT,
    ST_BACKOFF,
    ST_DONE
  } state_t;

  state_t                     state_q;
  logic [NUM_ACTORS-1:0]      pend_start_q, pend_done_q;
  logic                       exec_any_q;
  logic [31:0]                sleep_q;
  logic [31:0]                round_q;

  logic [NUM_ACTORS-1:0][31:0] ret;
  logic [NUM_ACTORS-1:0]       ret_hit;
  logic [NUM_ACTORS-1:0]       sel;
  logic [NUM_ACTORS-1:0]       pend_start_d, pend_done_d;
  logic                        sel_idle;
  logic                        exec_hit;
  state_t                      after_round;

  assign ret = actor_return;

  // Per-actor compare of the returned code against the "executed" value.
  for (genvar i = 0; i < NUM_ACTORS; i++) begin : g_lane
    assign ret_hit[i] = (ret[i] == EXECUTED_CODE);
  end

  // Launch selection, completion bookkeeping and the round-end decision.
  always_comb begin
    sel          = actor_enable & ((MODE == 0) ? {NUM_ACTORS{1'b1}} : actor_launch_predicate);
    sel_idle     = &(actor_idle | ~sel);
    exec_hit     = |(actor_done & pend_done_q & ret_hit);
    pend_start_d = pend_start_q & ~actor_ready;
    pend_done_d  = pend_done_q & ~actor_done;
    // Any execution means more work may be queued: go straight to another round.
    if (exec_any_q)
      after_round = ST_LAUNCH;
    else if ((MODE == 0) && !network_idle)
      after_round = (SLEEP_CYCLES == 0) ? ST_LAUNCH : ST_BACKOFF;
    else
      after_round = ST_DONE;
  end

  // Round sequencer; async reset drops all pending work immediately.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= ST_STAND_BY;
      pend_start_q <= '0;
      pend_done_q  <= '0;
      exec_any_q   <= 1'b0;
      sleep_q      <= '0;
      round_q      <= '0;
    end else begin
      case (state_q)
        ST_STAND_BY: begin
          if (ap_start) begin
            state_q    <= ST_LAUNCH;
            round_q    <= '0;
            exec_any_q <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          if (sel == '0) begin
            // Nothing selected: an empty round that executed nothing.
            round_q    <= round_q + 32'd1;
            exec_any_q <= 1'b0;
            sleep_q    <= 32'(SLEEP_CYCLES);
            state_q    <= after_round;
          end else if (sel_idle) begin
            pend_start_q <= sel;
            pend_done_q  <= sel;
            state_q      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (pend_done_q == '0) begin
            round_q      <= round_q + 32'd1;
            exec_any_q   <= 1'b0;
            sleep_q      <= 32'(SLEEP_CYCLES);
            pend_start_q <= '0;
            state_q      <= after_round;
          end else begin
            pend_start_q <= pend_start_d;
            pend_done_q  <= pend_done_d;
            if (exec_hit) exec_any_q <= 1'b1;
          end
        end
        ST_BACKOFF: begin
          if (sleep_q == 32'd1) state_q <= ST_LAUNCH;
          sleep_q <= sleep_q - 32'd1;
        end
        ST_DONE: state_q <= ST_STAND_BY;
        default: state_q <= ST_STAND_BY;
      endcase
    end
  end

  assign actor_start = (state_q == ST_WAIT) ? pend_start_q : '0;
  assign ap_idle     = (state_q == ST_STAND_BY);
  assign ap_done     = (state_q == ST_DONE);
  assign ap_ready    = (state_q == ST_DONE);
  assign round_count = round_q;

endmodule

// File: tb/tb_multi_trigger.sv
// tb_multi_trigger: four configurations share one stimulus stream; each is
// checked every cycle against a behavioural round model, plus literal checks.
module tb_multi_trigger;
  localparam int N  = 4;
  localparam int ND = 4;
  localparam int          MD [ND] = '{0, 1, 2, 0};
  localparam int          SL [ND] = '{8, 8, 2, 0};
  localparam logic [31:0] EX [ND] = '{32'd1, 32'd1, 32'hA5, 32'd1};

  localparam logic [2:0] P_IDLE = 3'd0, P_ARM = 3'd1, P_RUN = 3'd2, P_SLEEP = 3'd3, P_FIN = 3'd4;

  logic           clk = 1'b0;
  logic           rst, start, net;
  logic [N-1:0]   en, done, rdy, idl, pred;
  logic [32*N-1:0] ret;

  logic [N-1:0] st_o [ND];
  logic         dn_o [ND], rd_o [ND], id_o [ND];
  logic [31:0]  rc_o [ND];

  int vecs = 0;
  int bad  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    multi_trigger #(
      .NUM_ACTORS(N), .MODE(MD[g]), .EXECUTED_CODE(EX[g]), .SLEEP_CYCLES(SL[g])
    ) u_dut (
      .ap_clk(clk), .ap_rst(rst), .ap_start(start),
      .ap_done(dn_o[g]), .ap_ready(rd_o[g]), .ap_idle(id_o[g]),
      .network_idle(net), .actor_enable(en), .actor_return(ret),
      .actor_done(done), .actor_ready(rdy), .actor_idle(idl),
      .actor_launch_predicate(pred), .actor_start(st_o[g]), .round_count(rc_o[g])
    );
  end

  // Behavioural model: phase of the run, outstanding start/done sets, flags.
  typedef struct packed {
    logic [2:0]   ph;
    logic [N-1:0] ps;
    logic [N-1:0] pd;
    logic         ex;
    logic [31:0]  slp;
    logic [31:0]  rc;
  } mdl_t;

  mdl_t m [ND];

  function automatic mdl_t end_round(mdl_t s, int k);
    s.rc = s.rc + 32'd1;
    s.ps = '0;
    if (s.ex) begin
      s.ex = 1'b0;
      s.ph = P_ARM;
    end else if (MD[k] == 0 && !net) begin
      if (SL[k] == 0) s.ph = P_ARM;
      else begin
        s.ph  = P_SLEEP;
        s.slp = SL[k];
      end
    end else s.ph = P_FIN;
    return s;
  endfunction

  function automatic mdl_t mstep(mdl_t s, int k);
    mdl_t n;
    logic [N-1:0] want;
    bit ok;
    n = s;
    case (s.ph)
      P_IDLE: if (start) begin n.ph = P_ARM; n.rc = '0; n.ex = 1'b0; end
      P_ARM: begin
        want = en & ((MD[k] == 0) ? {N{1'b1}} : pred);
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (want[i] && !idl[i]) ok = 1'b0;
        if (want == '0) n = end_round(s, k);
        else if (ok) begin n.ps = want; n.pd = want; n.ph = P_RUN; end
      end
      P_RUN: begin
        if (s.pd == '0) n = end_round(s, k);
        else for (int i = 0; i < N; i++) begin
          if (s.pd[i] && done[i]) begin
            n.pd[i] = 1'b0;
            if (ret[32*i +: 32] == EX[k]) n.ex = 1'b1;
          end
          if (s.ps[i] && rdy[i]) n.ps[i] = 1'b0;
        end
      end
      P_SLEEP: begin
        n.slp = s.slp - 32'd1;
        if (n.slp == 0) n.ph = P_ARM;
      end
      P_FIN:   n.ph = P_IDLE;
      default: n.ph = P_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < ND; k++) m[k] <= rst ? '0 : mstep(m[k], k);
  end

  // Every-cycle compare of all outputs of every configuration.
  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      logic [N-1:0] es;
      logic ed, ei;
      es = (m[k].ph == P_RUN) ? m[k].ps : '0;
      ed = (m[k].ph == P_FIN);
      ei = (m[k].ph == P_IDLE);
      vecs++;
      if ({st_o[k], dn_o[k], rd_o[k], id_o[k], rc_o[k]} !== {es, ed, ed, ei, m[k].rc}) begin
        bad++;
        $display("FAIL model dut%0d t=%0t: got start=%h done=%b ready=%b idle=%b rc=%0d, want start=%h done=%b ready=%b idle=%b rc=%0d",
                 k, $time, st_o[k], dn_o[k], rd_o[k], id_o[k], rc_o[k], es, ed, ed, ei, m[k].rc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic quiet();
    start = 1'b0; net = 1'b1; en = '1; done = '0; rdy = '0; idl = '1; pred = '1; ret = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; quiet(); tick();
  endtask

  task automatic pulse_all(logic [N-1:0] d);
    done = d; rdy = d; tick(); done = '0; rdy = '0; ret = '0;
  endtask

  initial begin
    int cnt, ga, gd;
    bit seen, found;
    logic [N-1:0] acc;
    rst = 1'b1;
    quiet();
    tick(); tick();
    chk("reset_start", 32'(st_o[0]), 0);
    chk("reset_idle", 32'(id_o[0]), 1);
    chk("reset_done", 32'(dn_o[0]), 0);
    chk("reset_rc", rc_o[0], 0);
    rst = 1'b0; tick();

    // Two rounds: actor 2 executes in round 1, nothing in round 2.
    start = 1'b1; tick(); start = 1'b0;
    chk("latency_c1", 32'(st_o[0]), 0);
    tick();
    chk("latency_c2", 32'(st_o[0]), 32'hF);
    ret[64 +: 32] = 32'd1;
    pulse_all('1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (st_o[0] == 4'hF) found = 1'b1;
    end
    chk("round2_launch", 32'(found), 1);
    pulse_all('1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (dn_o[0]) cnt++;
      tick();
    end
    chk("round2_done_pulses", cnt, 1);
    chk("round2_rc", rc_o[0], 2);
    do_reset();

    // Input-trigger with empty predicate: empty round, quick done.
    pred = '0; start = 1'b1; tick(); start = 1'b0;
    seen = 1'b0; acc = '0;
    for (int i = 0; i < 3; i++) begin
      if (dn_o[1]) seen = 1'b1;
      acc |= st_o[1];
      tick();
    end
    chk("empty_done", 32'(seen), 1);
    chk("empty_nostart", 32'(acc), 0);
    chk("empty_rc", rc_o[1], 1);
    do_reset();

    // Actor 1 done+ready together while actor 3 is still busy.
    start = 1'b1; tick(); start = 1'b0; tick();
    pulse_all(4'b0010);
    chk("b2b_drop1", 32'(st_o[0]), 32'hD);
    pulse_all(4'b0101);
    chk("b2b_only3", 32'(st_o[0]), 32'h8);
    tick();
    chk("b2b_still_wait", 32'(dn_o[0]), 0);
    pulse_all(4'b1000);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (dn_o[0]) seen = 1'b1;
      tick();
    end
    chk("b2b_end", 32'(seen), 1);
    chk("b2b_rc", rc_o[0], 1);
    do_reset();

    // Reset mid-WAIT drops starts at once; later completions are ignored.
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("midwait_start", 32'(st_o[0]), 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("async_start_drop", 32'(st_o[0]), 0);
    chk("async_idle", 32'(id_o[0]), 1);
    tick(); rst = 1'b0;
    pulse_all('1);
    tick();
    chk("post_rst_idle", 32'(id_o[0]), 1);
    chk("post_rst_start", 32'(st_o[0]), 0);
    chk("post_rst_rc", rc_o[0], 0);

    // Actor 0 busy during launch: no start until it is idle.
    idl = 4'b1110; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("busy_hold", 32'(st_o[0]), 0);
      tick();
    end
    idl = '1; tick();
    chk("busy_release", 32'(st_o[0]), 32'hF);
    do_reset();

    // Busy network: backoff gap of SLEEP+2 idle cycles between rounds.
    net = 1'b0; start = 1'b1; tick(); start = 1'b0; tick();
    pulse_all('1);
    ga = -1; gd = -1;
    for (int i = 0; i <= 20; i++) begin
      if (ga < 0 && st_o[0] == 4'hF) ga = i;
      if (gd < 0 && st_o[3] == 4'hF) gd = i;
      tick();
    end
    chk("backoff_gap_s8", ga, 10);
    chk("backoff_gap_s0", gd, 2);
    net = 1'b1;
    pulse_all('1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (dn_o[0]) seen = 1'b1;
      tick();
    end
    chk("backoff_finish", 32'(seen), 1);
    chk("backoff_rc", rc_o[0], 2);
    do_reset();

    // Randomized traffic, including stray completions and async resets.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 24) == 0) net = ~net;
      if ($urandom_range(0, 99) == 0) en = N'($urandom);
      pred = N'($urandom);
      idl  = ~(N'($urandom) & N'($urandom) & N'($urandom));
      done = N'($urandom) & N'($urandom);
      rdy  = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: ret[32*i +: 32] = 32'd1;
          1: ret[32*i +: 32] = 32'hA5;
          2: ret[32*i +: 32] = 32'd0;
          default: ret[32*i +: 32] = $urandom;
        endcase
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end else tick();
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule

// File: doc/multi_trigger.md
MULTI_TRIGGER -- requirements
Module: multi_trigger

Interface
REQ-001 SHALL have parameter NUM_ACTORS, default 4, number of controlled actors (1..32).
REQ-002 SHALL have parameter MODE, default 0: 0 = actor trigger, 1 = input trigger, 2 = output trigger.
REQ-003 SHALL have parameter EXECUTED_CODE, default 32'd1, the actor return value meaning "executed".
REQ-004 SHALL have parameter SLEEP_CYCLES, default 8, backoff length between idle rounds (0 allowed).
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports: ap_clk in 1 clock; ap_rst in 1 async active-high reset.
REQ-007 SHALL have ports: ap_start in 1; ap_done out 1; ap_ready out 1; ap_idle out 1 (block-level handshake).
REQ-008 SHALL have ports: network_idle in 1; actor_enable in NUM_ACTORS, static per-run participation mask.
REQ-009 SHALL have ports: actor_return in 32*NUM_ACTORS, slice i = actor i; actor_done, actor_ready, actor_idle, actor_launch_predicate, each in NUM_ACTORS.
REQ-010 SHALL have ports: actor_start out NUM_ACTORS; round_count out 32, number of rounds completed in the current run.

Function
REQ-011 SHALL implement FSM states STAND_BY, LAUNCH, WAIT, BACKOFF, DONE.
REQ-012 STAND_BY: ap_idle=1; on ap_start=1 -> LAUNCH, clear round_count and executed_any.
REQ-013 LAUNCH: sel = actor_enable & (MODE==0 ? all-ones : actor_launch_predicate), sampled each cycle.
REQ-014 LAUNCH: SHALL wait until every sel actor has actor_idle=1, then load pending_start=sel and pending_done=sel, and go to WAIT.
REQ-015 LAUNCH with sel==0: SHALL skip WAIT and evaluate the round as not executed (REQ-019).
REQ-016 WAIT: actor_start[i]=pending_start[i]; pending_start[i] SHALL clear on actor_ready[i].
REQ-017 WAIT: pending_done[i] SHALL clear on actor_done[i]; on that same cycle, if the return slice equals EXECUTED_CODE, executed_any SHALL be set.
REQ-018 actor_done and actor_ready on the same cycle SHALL clear both bits; done/ready on non-pending actors SHALL be ignored.
REQ-019 Round end, when pending_done==0 in WAIT: round_count += 1 (wraps at 2^32).
REQ-020 Round end with executed_any=1: SHALL clear executed_any and go to LAUNCH.
REQ-021 Round end otherwise, MODE 0 with network_idle=0: SHALL go to BACKOFF; in all other cases SHALL go to DONE.
REQ-022 BACKOFF: counter SHALL load SLEEP_CYCLES, decrement each cycle, and go to LAUNCH on reaching 0; SLEEP_CYCLES=0 goes directly to LAUNCH.
REQ-023 DONE: ap_done=1 and ap_ready=1 for exactly one cycle, then STAND_BY; round_count SHALL hold until the next ap_start.
REQ-024 ap_start outside STAND_BY SHALL be ignored.
REQ-025 Latency: ap_start at cycle 0 with all actors idle -> actor_start high from cycle 2.
REQ-026 actor_start SHALL be 0 in every state except WAIT.

Reset
REQ-027 ap_rst=1 SHALL immediately force STAND_BY, clear pending masks, executed_any, counters and round_count.
REQ-028 During reset: actor_start=0, ap_done=0, ap_ready=0, ap_idle=1, round_count=0.
REQ-029 Reset asserted mid-WAIT SHALL drop all actor_start bits asynchronously; actor completions arriving afterwards SHALL be ignored.

Verification
REQ-030 MODE0, N=4, all enabled; actor 2 returns EXECUTED in round 1 and nothing executes in round 2; network_idle=1 -> two rounds, ap_done pulses once, round_count=2.
REQ-031 MODE0, no actor executes, network_idle=0 for 20 cycles, SLEEP_CYCLES=8 -> BACKOFF of 8 cycles between rounds; ap_done follows the first idle round after network_idle=1.
REQ-032 MODE1, predicate=4'b0000 -> no actor_start, ap_done within 3 cycles, round_count=1.
REQ-033 actor 1 asserts actor_done and actor_ready in the same cycle while actor 3 is still busy -> actor_start[1] drops, and the round ends only after actor 3's done.
REQ-034 ap_rst pulsed mid-WAIT -> actor_start=0 the same cycle, ap_idle=1; a later actor_done does not move the FSM.
REQ-035 actor 0 has actor_idle=0 in LAUNCH for 5 cycles -> no actor_start is asserted until it is idle, then all sel bits rise together.
